// File: rtl/normaliza_if.sv
// Request/result bundle for the leading-one normalizer.
// The master side issues start/r; the slave side returns the window and status.
interface normaliza_if #(
   parameter int IN_W  = 60,
   parameter int OUT_W = 18,
   parameter int SW    = 6
);
   logic             start;
   logic [IN_W-1:0]  r;
   logic [SW-1:0]    s;
   logic [OUT_W-1:0] y;
   logic             zero;
   logic             busy;
   logic             done;

   modport master (
      output start, r,
      input  s, y, zero, busy, done
   );

   modport slave (
      input  start, r,
      output s, y, zero, busy, done
   );
endinterface

// File: rtl/normaliza.sv
// Sequential leading-one normalizer: walks a window down from the top of a
// 60-bit product and stops at the first window whose top bit is set, giving
// the shift amount s and the 18-bit window y = r[s+17:s].
module normaliza #(
   parameter int IN_W  = 60,
   parameter int OUT_W = 18,
   parameter int SW    = 6,
   parameter int S_MAX = IN_W - OUT_W
) (
   input  logic        clk,
   input  logic        rst,
   normaliza_if.slave  bus
);

   typedef enum logic {IDLE, SCAN} state_t;

   state_t           state, state_nxt;
   logic [SW-1:0]    cnt, cnt_nxt;
   logic [IN_W-1:0]  r_reg, r_nxt;
   logic [SW-1:0]    s_q, s_nxt;
   logic [OUT_W-1:0] y_q, y_nxt;
   logic             zero_q, zero_nxt;
   logic             busy_q, busy_nxt;
   logic             done_q, done_nxt;
   logic [SW-1:0]    top_idx;

   // Slice the OUT_W-bit window starting at bit position sh.
   function automatic logic [OUT_W-1:0] window(input logic [IN_W-1:0] v,
                                               input logic [SW-1:0]   sh);
      window = v[sh +: OUT_W];
   endfunction

   // Index of the top bit of the current candidate window.
   assign top_idx = cnt + SW'(OUT_W - 1);

   // Next-state and next-output decode; everything holds unless changed.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      r_nxt     = r_reg;
      s_nxt     = s_q;
      y_nxt     = y_q;
      zero_nxt  = zero_q;
      busy_nxt  = busy_q;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               r_nxt     = bus.r;
               cnt_nxt   = SW'(S_MAX);
               busy_nxt  = 1'b1;
               state_nxt = SCAN;
            end
         end
         SCAN: begin
            // Stop on the first window with its top bit set; the bottom
            // window is the fallback for small values and for zero.
            if (r_reg[top_idx] || (cnt == '0)) begin
               y_nxt     = window(r_reg, cnt);
               s_nxt     = cnt;
               zero_nxt  = (r_reg == '0);
               done_nxt  = 1'b1;
               busy_nxt  = 1'b0;
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt - SW'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State and output registers; reset aborts any scan and clears outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         r_reg  <= '0;
         s_q    <= '0;
         y_q    <= '0;
         zero_q <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         r_reg  <= r_nxt;
         s_q    <= s_nxt;
         y_q    <= y_nxt;
         zero_q <= zero_nxt;
         busy_q <= busy_nxt;
         done_q <= done_nxt;
      end
   end

   assign bus.s    = s_q;
   assign bus.y    = y_q;
   assign bus.zero = zero_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;

endmodule

// File: tb/tb_normaliza.sv
// Testbench for normaliza: directed cases plus random requests checked
// against an arithmetic model of the leading-one normalization.
module tb_normaliza;
   localparam int IN_W  = 60;
   localparam int OUT_W = 18;
   localparam int SW    = 6;
   localparam int S_MAX = IN_W - OUT_W;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   normaliza_if #(.IN_W(IN_W), .OUT_W(OUT_W), .SW(SW)) bus ();

   normaliza dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: shift so the leading one lands at window bit 17, never below 0.
   function automatic void model(input logic [IN_W-1:0] v, output int s_e,
                                 output logic [OUT_W-1:0] y_e, output logic z_e);
      int msb;
      msb = -1;
      for (int i = 0; i < IN_W; i++) if (v[i]) msb = i;
      s_e = (msb > OUT_W - 1) ? msb - (OUT_W - 1) : 0;
      y_e = OUT_W'(v >> s_e);
      z_e = (v == '0);
   endfunction

   function automatic logic [OUT_W-1:0] ajuste(input logic [IN_W-1:0] v, input int sh);
      return OUT_W'(v >> sh);
   endfunction

   function automatic logic [IN_W-1:0] rand_word();
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      return t[IN_W-1:0];
   endfunction

   // Present a request for one edge, then scramble r to prove it was captured.
   task automatic do_start(input logic [IN_W-1:0] v);
      bus.start = 1'b1;
      bus.r     = v;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.r     = rand_word();
      check("busy_after_accept", bus.busy, 1'b1);
   endtask

   task automatic wait_done(inout int lat);
      while (lat < 100) begin
         @(posedge clk); #1;
         lat++;
         if (bus.done) break;
      end
      check("done_seen", bus.done, 1'b1);
   endtask

   task automatic verify(input string tag, input logic [IN_W-1:0] v, input int lat);
      int s_e;
      logic [OUT_W-1:0] y_e;
      logic z_e;
      model(v, s_e, y_e, z_e);
      check({tag, "_latency"}, lat, S_MAX - s_e + 1);
      check({tag, "_s"}, bus.s, s_e);
      check({tag, "_y"}, bus.y, y_e);
      check({tag, "_zero"}, bus.zero, z_e);
      check({tag, "_roundtrip"}, ajuste(v, int'(bus.s)), bus.y);
      check({tag, "_busy_low"}, bus.busy, 1'b0);
   endtask

   task automatic run_req(input string tag, input logic [IN_W-1:0] v);
      int lat;
      lat = 0;
      do_start(v);
      wait_done(lat);
      verify(tag, v, lat);
      @(posedge clk); #1;
      check({tag, "_done_pulse"}, bus.done, 1'b0);
   endtask

   initial begin
      int lat;
      logic seen;
      bus.start = 1'b0;
      bus.r     = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_s", bus.s, 0);
      check("rst_y", bus.y, 0);
      check("rst_zero", bus.zero, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);

      // Directed cases
      run_req("one", 60'h1);
      run_req("top", 60'd1 << 59);
      run_req("mid", (60'd1 << 30) | 60'h3);
      run_req("zero", 60'h0);
      check("zero_y_explicit", bus.y, 0);

      // Second start during scan is ignored; third start lands in done cycle
      lat = 0;
      do_start(60'd1 << 40);
      @(posedge clk); #1; lat++;
      @(posedge clk); #1; lat++;
      bus.start = 1'b1;
      bus.r     = 60'd1 << 59;
      @(posedge clk); #1; lat++;
      bus.start = 1'b0;
      bus.r     = rand_word();
      wait_done(lat);
      verify("ignore2nd", 60'd1 << 40, lat);
      check("ignore2nd_s23", bus.s, 23);
      lat = 0;
      do_start(60'd1 << 50);
      check("b2b_done_drop", bus.done, 1'b0);
      wait_done(lat);
      verify("b2b", 60'd1 << 50, lat);
      check("b2b_s33", bus.s, 33);

      // Reset mid-scan
      do_start(60'h5);
      repeat (9) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_busy", bus.busy, 0);
      check("abort_done", bus.done, 0);
      check("abort_s", bus.s, 0);
      check("abort_y", bus.y, 0);
      check("abort_zero", bus.zero, 0);
      seen = 1'b0;
      repeat (50) begin
         @(posedge clk); #1;
         if (bus.done) seen = 1'b1;
      end
      check("abort_no_done", seen, 1'b0);
      run_req("after_abort", 60'hFFFFF);
      check("after_abort_s2", bus.s, 2);
      check("after_abort_y", bus.y, 18'h3FFFF);

      // Random requests over a spread of magnitudes
      for (int k = 0; k < 25; k++) begin
         logic [IN_W-1:0] v;
         v = rand_word() >> $urandom_range(0, 60);
         run_req("rand", v);
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
